// File: rtl/hwsec_pkg.sv
// Shared datapath constants for the word/block gearboxes (packer and splitter).
package hwsec_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned WORDS  = 4;
   localparam int unsigned BLK_W  = WORD_W * WORDS;

   typedef logic [$clog2(WORDS)-1:0] cnt_t;

   // Slot 0 occupies the most-significant word of a slots*word_w vector.
   function automatic int unsigned slot_lsb(int unsigned k, int unsigned word_w,
                                            int unsigned slots);
      return (slots - 1 - k) * word_w;
   endfunction

endpackage

// File: rtl/block_packer_if.sv
// Word-in / block-out stream bundle for block_packer, plus the framing-error status pair.
interface block_packer_if #(
   parameter int unsigned WORD_W = hwsec_pkg::WORD_W,
   parameter int unsigned WORDS  = hwsec_pkg::WORDS
);
   localparam int unsigned BLK_W = WORD_W * WORDS;

   logic [WORD_W-1:0] in_word;
   logic              in_valid;
   logic              in_first;
   logic              in_ready;
   logic [BLK_W-1:0]  out_block;
   logic              out_valid;
   logic              out_ready;
   logic              err;
   logic              err_clr;

   modport slave (
      input  in_word, in_valid, in_first, out_ready, err_clr,
      output in_ready, out_block, out_valid, err
   );

   modport master (
      output in_word, in_valid, in_first, out_ready, err_clr,
      input  in_ready, out_block, out_valid, err
   );
endinterface

// File: rtl/block_packer.sv
// Serial word to 128-bit block gearbox; word 0 lands in the MSW of out_block.
// Optional sticky framing error is enabled with BLOCK_PACKER_ERR_EN.
module block_packer #(
   parameter int unsigned WORD_W = hwsec_pkg::WORD_W,
   parameter int unsigned WORDS  = hwsec_pkg::WORDS
) (
   input  logic          clk,
   input  logic          reset,
   block_packer_if.slave bus
);
   localparam int unsigned BLK_W = WORD_W * WORDS;
   localparam int unsigned ASM_W = BLK_W - WORD_W;
   localparam int unsigned CNT_W = $clog2(WORDS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ASM_W-1:0] asm_q, asm_d;
   logic [BLK_W-1:0] blk_q, blk_d;
   logic             valid_q, valid_d;
   logic             last_slot;
   logic             in_ready;
   logic             accept;

   assign last_slot    = (cnt_q == LAST);
   // Only the completing word ever waits on the output slot.
   assign in_ready     = !last_slot || !valid_q || bus.out_ready;
   assign accept       = bus.in_valid && in_ready;
   assign bus.in_ready = in_ready;

   always_comb begin
      cnt_d   = cnt_q;
      asm_d   = asm_q;
      blk_d   = blk_q;
      valid_d = valid_q && !bus.out_ready;
      if (accept) begin
         if (bus.in_first) begin
            asm_d = '0;
            asm_d[hwsec_pkg::slot_lsb(0, WORD_W, WORDS - 1) +: WORD_W] = bus.in_word;
            cnt_d = ONE;
         end else if (last_slot) begin
            blk_d   = {asm_q, bus.in_word};
            valid_d = 1'b1;
            cnt_d   = '0;
         end else begin
            asm_d[hwsec_pkg::slot_lsb(32'(cnt_q), WORD_W, WORDS - 1) +: WORD_W] = bus.in_word;
            cnt_d = cnt_q + ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         asm_q   <= '0;
         blk_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         asm_q   <= asm_d;
         blk_q   <= blk_d;
         valid_q <= valid_d;
      end
   end

   assign bus.out_block = blk_q;
   assign bus.out_valid = valid_q;

`ifdef BLOCK_PACKER_ERR_EN
   logic err_q, err_d;

   // A resync marker arriving mid-block is a framing error; set beats clear.
   always_comb begin
      err_d = err_q;
      if (bus.err_clr) err_d = 1'b0;
      if (accept && bus.in_first && (cnt_q != '0)) err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign bus.err = err_q;
`else
   logic err_clr_unused;
   assign err_clr_unused = bus.err_clr;
   assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_block_packer.sv
// Self-checking bench for block_packer: directed test-plan scenarios plus a randomized
// run against a queue-based reference model.
module tb_block_packer;
   import hwsec_pkg::*;

`ifdef BLOCK_PACKER_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   block_packer_if bus ();
   block_packer dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: got running, expected finished");
      $fatal(1, "timeout");
   end

   localparam logic [BLK_W-1:0] AES_BLK = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [BLK_W-1:0] B1_BLK  = 128'hAB348DF80C51984E2790436287AB34D1;
   localparam logic [BLK_W-1:0] B2_BLK  = 128'hACD670231AB1984E2790436287AB34D1;

   task automatic drive(input bit v, input logic [WORD_W-1:0] w, input bit f, input bit r,
                        input bit c);
      bus.in_valid  = v;
      bus.in_word   = w;
      bus.in_first  = f;
      bus.out_ready = r;
      bus.err_clr   = c;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WORD_W-1:0] word_of(input logic [BLK_W-1:0] b, input int k);
      return b[BLK_W-1-k*WORD_W -: WORD_W];
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      drive(0, '0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      checks += 4;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
      end
      if (bus.out_block !== '0) begin
         errors++; $display("FAIL reset_out_block: got %h expected 0", bus.out_block);
      end
      if (bus.err !== 1'b0) begin
         errors++; $display("FAIL reset_err: got %b expected 0", bus.err);
      end
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
      end
      @(negedge clk);
      reset = 1'b0;
      adv();
   endtask

   task automatic test_aes();
      for (int i = 0; i < WORDS; i++) begin
         drive(1, word_of(AES_BLK, i), i == 0, 1, 0);
         #1;
         checks += 2;
         if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL aes_in_ready[%0d]: got %b expected 1", i, bus.in_ready);
         end
         if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL aes_early_valid[%0d]: got %b expected 0", i, bus.out_valid);
         end
         adv();
      end
      drive(0, '0, 0, 1, 0);
      #1;
      checks += 2;
      if (bus.out_valid !== 1'b1) begin
         errors++; $display("FAIL aes_valid: got %b expected 1", bus.out_valid);
      end
      if (bus.out_block !== AES_BLK) begin
         errors++; $display("FAIL aes_block: got %h expected %h", bus.out_block, AES_BLK);
      end
      adv();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL aes_valid_one_cycle: got %b expected 0", bus.out_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic [2*BLK_W-1:0] both;
      both = {B1_BLK, B2_BLK};
      for (int i = 0; i < 2 * WORDS; i++) begin
         drive(1, both[2*BLK_W-1-i*WORD_W -: WORD_W], (i % WORDS) == 0, 1, 0);
         #1;
         checks += 2;
         if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, bus.in_ready);
         end
         if (bus.out_valid !== (i == WORDS)) begin
            errors++;
            $display("FAIL b2b_valid[%0d]: got %b expected %b", i, bus.out_valid, i == WORDS);
         end
         if (i == WORDS) begin
            checks++;
            if (bus.out_block !== B1_BLK) begin
               errors++; $display("FAIL b2b_block1: got %h expected %h", bus.out_block, B1_BLK);
            end
         end
         adv();
      end
      drive(0, '0, 0, 1, 0);
      #1;
      checks += 2;
      if (bus.out_valid !== 1'b1) begin
         errors++; $display("FAIL b2b_valid2: got %b expected 1", bus.out_valid);
      end
      if (bus.out_block !== B2_BLK) begin
         errors++; $display("FAIL b2b_block2: got %h expected %h", bus.out_block, B2_BLK);
      end
      adv();
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < WORDS; i++) begin
         drive(1, word_of(B1_BLK, i), i == 0, 0, 0);
         adv();
      end
      for (int i = 0; i < WORDS - 1; i++) begin
         drive(1, word_of(B2_BLK, i), i == 0, 0, 0);
         #1;
         checks += 2;
         if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 1", i, bus.in_ready);
         end
         if (bus.out_valid !== 1'b1 || bus.out_block !== B1_BLK) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got %b/%h expected 1/%h", i, bus.out_valid,
                     bus.out_block, B1_BLK);
         end
         adv();
      end
      drive(1, word_of(B2_BLK, WORDS - 1), 0, 0, 0);
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_stall: got %b expected 0", bus.in_ready);
      end
      adv();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_block !== B1_BLK) begin
         errors++;
         $display("FAIL bp_stable: got %b/%h expected 1/%h", bus.out_valid, bus.out_block, B1_BLK);
      end
      bus.out_ready = 1'b1;
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release: got %b expected 1", bus.in_ready);
      end
      adv();
      drive(0, '0, 0, 0, 0);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_block !== B2_BLK) begin
         errors++;
         $display("FAIL bp_block2: got %b/%h expected 1/%h", bus.out_valid, bus.out_block, B2_BLK);
      end
      bus.out_ready = 1'b1;
      adv();
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_drain: got %b expected 0", bus.out_valid);
      end
   endtask

   task automatic test_resync();
      for (int i = 0; i < 2; i++) begin
         drive(1, $urandom, i == 0, 1, 0);
         adv();
      end
      for (int i = 0; i < WORDS; i++) begin
         drive(1, word_of(AES_BLK, i), i == 0, 1, 0);
         #1;
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL resync_partial_out[%0d]: got %b expected 0", i, bus.out_valid);
         end
         adv();
      end
      drive(0, '0, 0, 1, 0);
      #1;
      checks += 2;
      if (bus.out_valid !== 1'b1 || bus.out_block !== AES_BLK) begin
         errors++;
         $display("FAIL resync_block: got %b/%h expected 1/%h", bus.out_valid, bus.out_block,
                  AES_BLK);
      end
      if (bus.err !== ERR_EN) begin
         errors++; $display("FAIL resync_err: got %b expected %b", bus.err, ERR_EN);
      end
      adv();
      checks++;
      if (bus.err !== ERR_EN) begin
         errors++; $display("FAIL resync_err_sticky: got %b expected %b", bus.err, ERR_EN);
      end
      drive(0, '0, 0, 1, 1);
      adv();
      checks++;
      if (bus.err !== 1'b0) begin
         errors++; $display("FAIL resync_err_clr: got %b expected 0", bus.err);
      end
      // Set and clear in the same cycle: set must win.
      drive(1, $urandom, 1, 1, 0);
      adv();
      drive(1, $urandom, 1, 1, 1);
      adv();
      checks++;
      if (bus.err !== ERR_EN) begin
         errors++; $display("FAIL resync_set_wins: got %b expected %b", bus.err, ERR_EN);
      end
      for (int i = 1; i < WORDS; i++) begin
         drive(1, $urandom, 0, 1, 0);
         adv();
      end
      drive(0, '0, 0, 1, 1);
      adv();
      bus.err_clr = 1'b0;
      checks++;
      if (bus.err !== 1'b0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL resync_cleanup: got err=%b valid=%b expected 0/0", bus.err, bus.out_valid);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < WORDS; i++) begin
         drive(1, word_of(B1_BLK, i), i == 0, 0, 0);
         adv();
      end
      for (int i = 0; i < WORDS - 1; i++) begin
         drive(1, word_of(B2_BLK, i), i == 0, 0, 0);
         adv();
      end
      drive(0, '0, 0, 0, 0);
      reset = 1'b1;
      #1;
      checks += 3;
      if (bus.out_valid !== 1'b0 || bus.out_block !== '0) begin
         errors++;
         $display("FAIL mid_reset_out: got %b/%h expected 0/0", bus.out_valid, bus.out_block);
      end
      if (bus.err !== 1'b0) begin
         errors++; $display("FAIL mid_reset_err: got %b expected 0", bus.err);
      end
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL mid_reset_in_ready: got %b expected 1", bus.in_ready);
      end
      @(negedge clk);
      reset = 1'b0;
      adv();
      // No in_first here: the word counter itself must be back at 0.
      for (int i = 0; i < WORDS; i++) begin
         drive(1, word_of(AES_BLK, i), 0, 1, 0);
         #1;
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_stale_out[%0d]: got %b expected 0", i, bus.out_valid);
         end
         adv();
      end
      drive(0, '0, 0, 1, 0);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_block !== AES_BLK) begin
         errors++;
         $display("FAIL mid_next_block: got %b/%h expected 1/%h", bus.out_valid, bus.out_block,
                  AES_BLK);
      end
      adv();
   endtask

   task automatic test_random();
      logic [WORD_W-1:0] part[$];
      logic [BLK_W-1:0]  pend[$];
      logic [BLK_W-1:0]  blk;
      bit m_err, exp_ready, v, f, r, c, set;
      logic [WORD_W-1:0] w;
      reset = 1'b1;
      drive(0, '0, 0, 0, 0);
      adv();
      @(negedge clk);
      reset = 1'b0;
      adv();
      m_err = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         v = ($urandom_range(0, 9) < 7);
         f = ($urandom_range(0, 9) < 2);
         r = ($urandom_range(0, 9) < 5);
         c = ($urandom_range(0, 19) == 0);
         w = $urandom;
         drive(v, w, f, r, c);
         #1;
         exp_ready = !(part.size() == WORDS - 1 && pend.size() != 0 && !r);
         checks += 3;
         if (bus.in_ready !== exp_ready) begin
            errors++; $display("FAIL rnd_in_ready@%0d: got %b expected %b", cyc, bus.in_ready,
                               exp_ready);
         end
         if (bus.out_valid !== (pend.size() != 0)) begin
            errors++; $display("FAIL rnd_out_valid@%0d: got %b expected %b", cyc, bus.out_valid,
                               pend.size() != 0);
         end
         if (bus.err !== m_err) begin
            errors++; $display("FAIL rnd_err@%0d: got %b expected %b", cyc, bus.err, m_err);
         end
         if (pend.size() != 0) begin
            checks++;
            if (bus.out_block !== pend[0]) begin
               errors++; $display("FAIL rnd_block@%0d: got %h expected %h", cyc, bus.out_block,
                                  pend[0]);
            end
         end
         set = 1'b0;
         if (pend.size() != 0 && r) void'(pend.pop_front());
         if (v && exp_ready) begin
            if (f) begin
               set = (part.size() != 0);
               part.delete();
            end
            part.push_back(w);
            if (part.size() == WORDS) begin
               blk = '0;
               foreach (part[k]) blk = {blk[BLK_W-WORD_W-1:0], part[k]};
               pend.push_back(blk);
               part.delete();
            end
         end
         m_err = ERR_EN && (set || (m_err && !c));
         adv();
      end
      drive(0, '0, 0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_aes();
      test_back_to_back();
      test_backpressure();
      test_resync();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
